// File: rtl/cpu_pkg.sv
// Shared types and constants for the operand-fetch stage and its scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    OUT  = 2'd3
  } of_state_e;

endpackage

// File: rtl/of_scoreboard.sv
// Busy vector of destination registers owned by instructions dispatched to execute.
// Latency: set/clear take effect the cycle after; lookups are combinational.
// Backpressure: none; a set and a clear of the same register in one cycle leave it busy.
module of_scoreboard
  import cpu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_addr_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_addr_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o
);

  logic [REG_COUNT-1:0] r_busy;
  logic [REG_COUNT-1:0] w_busy_nxt;

  // Clear first so a same-cycle set overrides it; x0 can never become busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (clr_en_i) w_busy_nxt[clr_addr_i] = 1'b0;
    if (set_en_i && (set_addr_i != ZERO_REG)) w_busy_nxt[set_addr_i] = 1'b1;
    w_busy_nxt[ZERO_REG] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_busy <= '0;
    else         r_busy <= w_busy_nxt;
  end

  assign rs1_busy_o = r_busy[rs1_addr_i];
  assign rs2_busy_o = r_busy[rs2_addr_i];

endmodule

// File: rtl/operand_fetch.sv
// Issues register-file reads (with piggybacked writeback) per decoded instruction and forwards operands to execute.
// Latency: dec handshake cycle 0, rf request cycle 1, ex_valid_o the cycle after the rf response handshake.
// Backpressure: one rf transaction outstanding; decode stalls on RAW hazards, rf/ex stalls hold outputs stable.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dec_valid_i,
  output logic                  dec_ready_o,
  input  logic [REG_ADDR_W-1:0] dec_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] dec_rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] dec_rd_addr_i,
  input  logic                  dec_uses_rd_i,
  input  logic [PAYLOAD_W-1:0]  dec_payload_i,
  input  logic                  wb_valid_i,
  output logic                  wb_ready_o,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
  input  logic [XLEN-1:0]       wb_rd_data_i,
  output logic                  rf_valid_o,
  input  logic                  rf_ready_i,
  output logic [REG_ADDR_W-1:0] rf_rs1_addr_o,
  output logic [REG_ADDR_W-1:0] rf_rs2_addr_o,
  output logic [REG_ADDR_W-1:0] rf_rd_addr_o,
  output logic [XLEN-1:0]       rf_rd_data_o,
  output logic                  rf_wr_en_o,
  input  logic                  rf_valid_i,
  output logic                  rf_ready_o,
  input  logic [XLEN-1:0]       rf_rs1_data_i,
  input  logic [XLEN-1:0]       rf_rs2_data_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [XLEN-1:0]       ex_rs1_data_o,
  output logic [XLEN-1:0]       ex_rs2_data_o,
  output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
  output logic                  ex_uses_rd_o,
  output logic [PAYLOAD_W-1:0]  ex_payload_o
);

  of_state_e             r_state, w_state_nxt;
  logic [REG_ADDR_W-1:0] r_rs1, r_rs2, r_rd, r_wb_addr;
  logic                  r_uses_rd, r_wr_en, r_wr_only;
  logic [PAYLOAD_W-1:0]  r_payload;
  logic [XLEN-1:0]       r_wb_data, r_rs1_data, r_rs2_data;

  logic w_rs1_busy, w_rs2_busy, w_haz1, w_haz2;
  logic w_dec_ready, w_wb_ready, w_rf_valid, w_rf_ready, w_ex_valid;

  // A busy source is not a hazard when the pending writeback supplies it now.
  assign w_haz1 = w_rs1_busy && (dec_rs1_addr_i != ZERO_REG) &&
                  !(wb_valid_i && (wb_rd_addr_i == dec_rs1_addr_i));
  assign w_haz2 = w_rs2_busy && (dec_rs2_addr_i != ZERO_REG) &&
                  !(wb_valid_i && (wb_rd_addr_i == dec_rs2_addr_i));

  // Next-state and handshake outputs; readies are held low while reset is asserted.
  always_comb begin
    w_state_nxt = r_state;
    w_dec_ready = 1'b0;
    w_wb_ready  = 1'b0;
    w_rf_valid  = 1'b0;
    w_rf_ready  = 1'b0;
    w_ex_valid  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_dec_ready = rst_ni && dec_valid_i && !w_haz1 && !w_haz2;
        w_wb_ready  = rst_ni && wb_valid_i;
        if (w_dec_ready || w_wb_ready) w_state_nxt = REQ;
      end
      REQ: begin
        w_rf_valid = 1'b1;
        if (rf_ready_i) w_state_nxt = RSP;
      end
      RSP: begin
        w_rf_ready = 1'b1;
        if (rf_valid_i) w_state_nxt = r_wr_only ? IDLE : OUT;
      end
      OUT: begin
        w_ex_valid = 1'b1;
        if (ex_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Latch the accepted instruction/writeback; capture operands with writeback bypass.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_uses_rd  <= 1'b0;
      r_payload  <= '0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_only  <= 1'b0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
    end else begin
      if (w_dec_ready || w_wb_ready) begin
        r_wr_only <= !w_dec_ready;
        r_wr_en   <= w_wb_ready && (wb_rd_addr_i != ZERO_REG);
        r_wb_addr <= w_wb_ready ? wb_rd_addr_i : ZERO_REG;
        r_wb_data <= w_wb_ready ? wb_rd_data_i : '0;
        r_rs1     <= w_dec_ready ? dec_rs1_addr_i : ZERO_REG;
        r_rs2     <= w_dec_ready ? dec_rs2_addr_i : ZERO_REG;
        if (w_dec_ready) begin
          r_rd      <= dec_rd_addr_i;
          r_uses_rd <= dec_uses_rd_i;
          r_payload <= dec_payload_i;
        end
      end
      // The register file returns pre-write values, so forward the latched write.
      if (w_rf_ready && rf_valid_i && !r_wr_only) begin
        r_rs1_data <= (r_wr_en && (r_wb_addr == r_rs1)) ? r_wb_data : rf_rs1_data_i;
        r_rs2_data <= (r_wr_en && (r_wb_addr == r_rs2)) ? r_wb_data : rf_rs2_data_i;
      end
    end
  end

  of_scoreboard u_sb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .set_en_i   (w_ex_valid && ex_ready_i && r_uses_rd),
    .set_addr_i (r_rd),
    .clr_en_i   (w_rf_valid && rf_ready_i && r_wr_en),
    .clr_addr_i (r_wb_addr),
    .rs1_addr_i (dec_rs1_addr_i),
    .rs2_addr_i (dec_rs2_addr_i),
    .rs1_busy_o (w_rs1_busy),
    .rs2_busy_o (w_rs2_busy)
  );

  assign dec_ready_o   = w_dec_ready;
  assign wb_ready_o    = w_wb_ready;
  assign rf_valid_o    = w_rf_valid;
  assign rf_rs1_addr_o = r_rs1;
  assign rf_rs2_addr_o = r_rs2;
  assign rf_rd_addr_o  = r_wb_addr;
  assign rf_rd_data_o  = r_wb_data;
  assign rf_wr_en_o    = w_rf_valid && r_wr_en;
  assign rf_ready_o    = w_rf_ready;
  assign ex_valid_o    = w_ex_valid;
  assign ex_rs1_data_o = r_rs1_data;
  assign ex_rs2_data_o = r_rs2_data;
  assign ex_rd_addr_o  = r_rd;
  assign ex_uses_rd_o  = r_uses_rd;
  assign ex_payload_o  = r_payload;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, write-only, read, RAW stall/bypass, collision, backpressure, x0, mid-reset.
// Latency: checks sampled 1ns after each rising edge.
// Backpressure: exercised by holding rf_ready_i and ex_ready_i low.
module tb_operand_fetch;
  import cpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        dec_valid_i = 1'b0, dec_ready_o;
  logic [4:0]  dec_rs1_addr_i = '0, dec_rs2_addr_i = '0, dec_rd_addr_i = '0;
  logic        dec_uses_rd_i = 1'b0;
  logic [31:0] dec_payload_i = '0;
  logic        wb_valid_i = 1'b0, wb_ready_o;
  logic [4:0]  wb_rd_addr_i = '0;
  logic [31:0] wb_rd_data_i = '0;
  logic        rf_valid_o, rf_ready_i = 1'b1;
  logic [4:0]  rf_rs1_addr_o, rf_rs2_addr_o, rf_rd_addr_o;
  logic [31:0] rf_rd_data_o;
  logic        rf_wr_en_o;
  logic        rf_valid_i = 1'b1, rf_ready_o;
  logic [31:0] rf_rs1_data_i = '0, rf_rs2_data_i = '0;
  logic        ex_valid_o, ex_ready_i = 1'b1;
  logic [31:0] ex_rs1_data_o, ex_rs2_data_o;
  logic [4:0]  ex_rd_addr_o;
  logic        ex_uses_rd_o;
  logic [31:0] ex_payload_o;

  int n_err = 0;
  int n_checks = 0;

  operand_fetch #(.XLEN(32), .PAYLOAD_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_rs1_addr_i(dec_rs1_addr_i), .dec_rs2_addr_i(dec_rs2_addr_i),
    .dec_rd_addr_i(dec_rd_addr_i), .dec_uses_rd_i(dec_uses_rd_i),
    .dec_payload_i(dec_payload_i),
    .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
    .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_data_i(wb_rd_data_i),
    .rf_valid_o(rf_valid_o), .rf_ready_i(rf_ready_i),
    .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs2_addr_o(rf_rs2_addr_o),
    .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_data_o(rf_rd_data_o), .rf_wr_en_o(rf_wr_en_o),
    .rf_valid_i(rf_valid_i), .rf_ready_o(rf_ready_o),
    .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_uses_rd_o(ex_uses_rd_o),
    .ex_payload_o(ex_payload_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Write-only transaction with rf always ready/valid; returns in IDLE.
  task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
    wb_valid_i = 1'b1; wb_rd_addr_i = a; wb_rd_data_i = d;
    #1; cyc();
    wb_valid_i = 1'b0;
    cyc(); cyc();
  endtask

  // Full read transaction with no stalls; returns in IDLE.
  task automatic do_dec(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] rd,
                        input logic uses, input logic [31:0] pl);
    dec_valid_i = 1'b1; dec_rs1_addr_i = s1; dec_rs2_addr_i = s2;
    dec_rd_addr_i = rd; dec_uses_rd_i = uses; dec_payload_i = pl;
    #1; cyc();
    dec_valid_i = 1'b0;
    cyc(); cyc(); cyc();
  endtask

  initial begin
    // Reset state with requests pending at the inputs.
    dec_valid_i = 1'b1; wb_valid_i = 1'b1;
    repeat (2) cyc();
    chk("rst_dec_ready", dec_ready_o, 0);
    chk("rst_wb_ready", wb_ready_o, 0);
    chk("rst_rf_valid", rf_valid_o, 0);
    chk("rst_rf_ready", rf_ready_o, 0);
    chk("rst_ex_valid", ex_valid_o, 0);
    dec_valid_i = 1'b0; wb_valid_i = 1'b0;
    rst_ni = 1'b1;
    cyc();

    // Write-only: x5 = DEADBEEF.
    wb_valid_i = 1'b1; wb_rd_addr_i = 5'd5; wb_rd_data_i = 32'hDEADBEEF;
    #1;
    chk("wo_wb_ready", wb_ready_o, 1);
    cyc();
    wb_valid_i = 1'b0;
    chk("wo_req", {rf_valid_o, rf_wr_en_o, rf_rd_addr_o, rf_rs1_addr_o, rf_rs2_addr_o}, {1'b1, 1'b1, 5'd5, 5'd0, 5'd0});
    chk("wo_data", rf_rd_data_o, 32'hDEADBEEF);
    cyc();
    chk("wo_rsp", {rf_ready_o, rf_valid_o}, 2'b10);
    cyc();
    chk("wo_idle", {ex_valid_o, rf_ready_o, rf_valid_o}, 3'b000);
    cyc();
    chk("wo_no_ex", ex_valid_o, 0);

    // Simple read of x1 after writing 0x11.
    do_wb(5'd1, 32'h11);
    rf_rs1_data_i = 32'h11; rf_rs2_data_i = 32'h0;
    dec_valid_i = 1'b1; dec_rs1_addr_i = 5'd1; dec_rs2_addr_i = 5'd0;
    dec_rd_addr_i = 5'd2; dec_uses_rd_i = 1'b0; dec_payload_i = 32'hA5A5;
    #1;
    chk("rd_dec_ready", dec_ready_o, 1);
    cyc();
    dec_valid_i = 1'b0;
    chk("rd_req", {rf_valid_o, rf_rs1_addr_o, rf_wr_en_o}, {1'b1, 5'd1, 1'b0});
    cyc();
    chk("rd_ex_early", ex_valid_o, 0);
    cyc();
    chk("rd_ex_valid", ex_valid_o, 1);
    chk("rd_ops", {ex_rs1_data_o, ex_rs2_data_o}, {32'h11, 32'h0});
    chk("rd_payload", ex_payload_o, 32'hA5A5);
    cyc();
    chk("rd_done", ex_valid_o, 0);

    // RAW stall on x3 resolved by a piggybacked writeback.
    do_dec(5'd0, 5'd0, 5'd3, 1'b1, 32'h3);
    chk("raw_busy_set", dut.u_sb.r_busy[3], 1);
    dec_valid_i = 1'b1; dec_rs1_addr_i = 5'd3; dec_rs2_addr_i = 5'd0;
    dec_rd_addr_i = 5'd6; dec_uses_rd_i = 1'b0; dec_payload_i = 32'h33;
    #1;
    chk("raw_stall0", dec_ready_o, 0);
    cyc();
    chk("raw_stall1", {dec_ready_o, rf_valid_o}, 2'b00);
    wb_valid_i = 1'b1; wb_rd_addr_i = 5'd3; wb_rd_data_i = 32'h42;
    #1;
    chk("raw_release", {dec_ready_o, wb_ready_o}, 2'b11);
    cyc();
    dec_valid_i = 1'b0; wb_valid_i = 1'b0;
    rf_rs1_data_i = 32'h99;
    chk("raw_req", {rf_wr_en_o, rf_rs1_addr_o, rf_rd_addr_o}, {1'b1, 5'd3, 5'd3});
    cyc();
    chk("raw_busy_clr", dut.u_sb.r_busy[3], 0);
    cyc();
    chk("raw_bypass", ex_rs1_data_o, 32'h42);
    cyc();
    chk("raw_busy_end", dut.u_sb.r_busy[3], 0);

    // x4 dispatched with an older writeback of x4 riding along: ends busy.
    do_dec(5'd0, 5'd0, 5'd4, 1'b1, 32'h4);
    dec_valid_i = 1'b1; dec_rs1_addr_i = 5'd0; dec_rs2_addr_i = 5'd0;
    dec_rd_addr_i = 5'd4; dec_uses_rd_i = 1'b1; dec_payload_i = 32'h44;
    wb_valid_i = 1'b1; wb_rd_addr_i = 5'd4; wb_rd_data_i = 32'h4444;
    #1;
    chk("col_accept", {dec_ready_o, wb_ready_o}, 2'b11);
    cyc();
    dec_valid_i = 1'b0; wb_valid_i = 1'b0;
    cyc();
    chk("col_cleared", dut.u_sb.r_busy[4], 0);
    cyc();
    chk("col_ex", {ex_valid_o, ex_uses_rd_o, ex_rd_addr_o}, {1'b1, 1'b1, 5'd4});
    cyc();
    chk("col_busy4", dut.u_sb.r_busy[4], 1);

    // Backpressure: rf_ready_i low 5 cycles, then ex_ready_i low 4 cycles.
    rf_ready_i = 1'b0;
    rf_rs1_data_i = 32'hAA; rf_rs2_data_i = 32'hBB;
    dec_valid_i = 1'b1; dec_rs1_addr_i = 5'd2; dec_rs2_addr_i = 5'd7;
    dec_rd_addr_i = 5'd8; dec_uses_rd_i = 1'b0; dec_payload_i = 32'h1234;
    #1; cyc();
    dec_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rf_hold", {rf_valid_o, rf_rs1_addr_o, rf_rs2_addr_o, rf_ready_o}, {1'b1, 5'd2, 5'd7, 1'b0});
      cyc();
    end
    rf_ready_i = 1'b1; ex_ready_i = 1'b0;
    #1; cyc();
    chk("bp_rsp", {rf_ready_o, rf_valid_o}, 2'b10);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("bp_ex_hold", {ex_valid_o, rf_valid_o, ex_rs1_data_o, ex_rs2_data_o, ex_payload_o[15:0]},
          {1'b1, 1'b0, 32'hAA, 32'hBB, 16'h1234});
      cyc();
    end
    ex_ready_i = 1'b1;
    #1; cyc();
    chk("bp_done", {ex_valid_o, rf_valid_o}, 2'b00);

    // x0 rules.
    wb_valid_i = 1'b1; wb_rd_addr_i = 5'd0; wb_rd_data_i = 32'hFF;
    #1; cyc();
    wb_valid_i = 1'b0;
    chk("x0_no_wr", {rf_valid_o, rf_wr_en_o}, 2'b10);
    cyc(); cyc();
    do_dec(5'd0, 5'd0, 5'd0, 1'b1, 32'h0);
    chk("x0_busy_vec", dut.u_sb.r_busy, 32'h0000_0010);
    dec_valid_i = 1'b1; dec_rs1_addr_i = 5'd0; dec_rs2_addr_i = 5'd0;
    dec_rd_addr_i = 5'd0; dec_uses_rd_i = 1'b0;
    #1;
    chk("x0_no_stall", dec_ready_o, 1);
    cyc();
    dec_valid_i = 1'b0;
    cyc(); cyc(); cyc();

    // Reset while waiting for the response.
    do_dec(5'd0, 5'd0, 5'd9, 1'b1, 32'h9);
    rf_valid_i = 1'b0;
    dec_valid_i = 1'b1; dec_rs1_addr_i = 5'd1; dec_rs2_addr_i = 5'd0;
    dec_rd_addr_i = 5'd10; dec_uses_rd_i = 1'b1; dec_payload_i = 32'hBEEF;
    #1; cyc();
    cyc();
    chk("mr_in_rsp", rf_ready_o, 1);
    wb_valid_i = 1'b1; wb_rd_addr_i = 5'd2;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mr_readies", {dec_ready_o, wb_ready_o, rf_ready_o}, 3'b000);
    chk("mr_valids", {rf_valid_o, ex_valid_o, rf_wr_en_o}, 3'b000);
    chk("mr_regs", {rf_rs1_addr_o, ex_rd_addr_o, ex_payload_o}, 42'h0);
    chk("mr_busy", dut.u_sb.r_busy, 32'h0);
    dec_valid_i = 1'b0; wb_valid_i = 1'b0; rf_valid_i = 1'b1;
    cyc();
    rst_ni = 1'b1;
    cyc();
    chk("mr_idle", dut.r_state, IDLE);
    do_wb(5'd6, 32'h66);
    chk("mr_after", {rf_valid_o, ex_valid_o}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
